// File: rtl/node_act_collect.sv
// node_act_collect: shift/activate node results and collect them into a layer vector with valid/ready output
module node_act_collect #(
  parameter int NODES = 200,
  parameter int DW    = 16,
  parameter int SHIFT = 0,
  parameter int ACT   = 1,
  localparam int CW   = $clog2(NODES+1),
  localparam int IW   = $clog2(NODES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [DW-1:0]              x,
  input  logic                       flush,
  output logic [NODES-1:0][DW-1:0]   layer_out,
  output logic                       layer_valid,
  input  logic                       layer_ready,
  output logic [CW-1:0]              fill_count,
  output logic                       overflow
);
  typedef enum logic {FILL, FULL} state_t;
  state_t state;
  logic signed [DW-1:0] s;
  logic [DW-1:0] y;
  logic [IW-1:0] idx;
  assign s = $signed(x) >>> SHIFT;
  assign y = (ACT != 0 && s[DW-1]) ? '0 : s;
  assign idx = fill_count[IW-1:0];
  assign layer_valid = state == FULL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_out  <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      state      <= FILL;
    end else if (state == FILL) begin
      if (flush) fill_count <= '0;
      else if (valid_in) begin
        layer_out[idx] <= y;
        fill_count     <= fill_count + CW'(1);
        if (fill_count == CW'(NODES-1)) state <= FULL;
      end
    end else if (layer_ready) begin
      // the handshake edge also accepts a new sample into entry 0
      state      <= FILL;
      fill_count <= valid_in ? CW'(1) : '0;
      if (valid_in) layer_out[0] <= y;
    end else if (valid_in) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_node_act_collect.sv
// tb_node_act_collect: table-driven check of fill, stall, back-to-back, flush, scaling and async reset
module tb_node_act_collect;
  logic clk = 0, rst = 1, valid_in = 0, flush = 0, layer_ready = 0;
  logic [15:0] x = 0;
  logic [3:0][15:0] lo0, lo1, lo2;
  logic lv0, lv1, lv2, ov0, ov1, ov2;
  logic [2:0] fc0, fc1, fc2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  node_act_collect #(.NODES(4), .DW(16), .SHIFT(0), .ACT(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .x(x), .flush(flush),
    .layer_out(lo0), .layer_valid(lv0), .layer_ready(layer_ready),
    .fill_count(fc0), .overflow(ov0));
  node_act_collect #(.NODES(4), .DW(16), .SHIFT(2), .ACT(0)) dut_id (
    .clk(clk), .rst(rst), .valid_in(valid_in), .x(x), .flush(flush),
    .layer_out(lo1), .layer_valid(lv1), .layer_ready(layer_ready),
    .fill_count(fc1), .overflow(ov1));
  node_act_collect #(.NODES(4), .DW(16), .SHIFT(2), .ACT(1)) dut_relu (
    .clk(clk), .rst(rst), .valid_in(valid_in), .x(x), .flush(flush),
    .layer_out(lo2), .layer_valid(lv2), .layer_ready(layer_ready),
    .fill_count(fc2), .overflow(ov2));

  typedef struct {
    logic v; logic [15:0] x; logic fl, rdy;
    logic lv; int cnt; logic ov; logic [3:0] m; logic [3:0][15:0] o;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic lv, input int cnt, input logic ov,
                          input logic [3:0] m, input logic [3:0][15:0] o);
    chk({tag, " layer_valid"}, lv0, lv);
    chk({tag, " fill_count"}, fc0, cnt);
    chk({tag, " overflow"}, ov0, ov);
    for (int i = 0; i < 4; i++)
      if (m[i]) chk($sformatf("%s layer_out[%0d]", tag, i), lo0[i], o[i]);
  endtask

  task automatic step(input logic v, input logic [15:0] xv, input logic fl, input logic rdy);
    valid_in = v; x = xv; flush = fl; layer_ready = rdy;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(logic v, logic [15:0] xv, logic fl, logic rdy, logic lv,
                              int cnt, logic ov, logic [3:0] m, logic [3:0][15:0] o);
    return '{v, xv, fl, rdy, lv, cnt, ov, m, o};
  endfunction

  initial begin
    // basic fill 5,-3,7,0 with an idle cycle in between
    tbl.push_back(mk(1, 16'd5,    0, 0, 0, 1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}));
    tbl.push_back(mk(0, 16'd99,   0, 0, 0, 1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}));
    tbl.push_back(mk(1, -16'sd3,  0, 0, 0, 2, 0, 4'b0011, {16'd0, 16'd0, 16'd0, 16'd5}));
    tbl.push_back(mk(1, 16'd7,    0, 0, 0, 3, 0, 4'b0111, {16'd0, 16'd7, 16'd0, 16'd5}));
    tbl.push_back(mk(1, 16'd0,    0, 0, 1, 4, 0, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5}));
    // stall in FULL: samples dropped, overflow sticky, flush ignored
    tbl.push_back(mk(1, 16'd9,    0, 0, 1, 4, 1, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5}));
    tbl.push_back(mk(1, 16'd9,    0, 0, 1, 4, 1, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5}));
    tbl.push_back(mk(1, 16'd9,    0, 0, 1, 4, 1, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5}));
    tbl.push_back(mk(0, 16'd0,    1, 0, 1, 4, 1, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5}));
    // back-to-back: handshake with a sample in the same cycle
    tbl.push_back(mk(1, 16'd11,   0, 1, 0, 1, 1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd11}));
    tbl.push_back(mk(1, 16'd1,    0, 0, 0, 2, 1, 4'b0011, {16'd0, 16'd0, 16'd1, 16'd11}));
    tbl.push_back(mk(1, 16'd2,    0, 0, 0, 3, 1, 4'b0111, {16'd0, 16'd2, 16'd1, 16'd11}));
    tbl.push_back(mk(1, 16'd3,    0, 0, 1, 4, 1, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd11}));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 1, 4'b0000, '0));
    // flush after 2 samples, then a full vector from entry 0
    tbl.push_back(mk(1, 16'd6,    0, 0, 0, 1, 1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd6}));
    tbl.push_back(mk(1, 16'd8,    0, 0, 0, 2, 1, 4'b0011, {16'd0, 16'd0, 16'd8, 16'd6}));
    tbl.push_back(mk(1, 16'd4,    1, 0, 0, 0, 1, 4'b0000, '0));
    tbl.push_back(mk(1, 16'd21,   0, 0, 0, 1, 1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd21}));
    tbl.push_back(mk(1, 16'd22,   0, 0, 0, 2, 1, 4'b0011, {16'd0, 16'd0, 16'd22, 16'd21}));
    tbl.push_back(mk(1, 16'd23,   0, 0, 0, 3, 1, 4'b0111, {16'd0, 16'd23, 16'd22, 16'd21}));
    tbl.push_back(mk(1, 16'd24,   0, 0, 1, 4, 1, 4'b1111, {16'd24, 16'd23, 16'd22, 16'd21}));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 1, 4'b0000, '0));

    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 0, 0, 0, 4'b1111, '0);
    rst = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].x, tbl[i].fl, tbl[i].rdy);
      chk_main($sformatf("vec%0d", i), tbl[i].lv, tbl[i].cnt, tbl[i].ov, tbl[i].m, tbl[i].o);
    end

    // shift by 2 with identity and ReLU
    step(1, 16'hFFF0, 0, 0);
    step(1, 16'd20, 0, 0);
    chk("shift id out0", lo1[0], 16'hFFFC);
    chk("shift id out1", lo1[1], 16'd5);
    chk("shift relu out0", lo2[0], 16'd0);
    chk("shift relu out1", lo2[1], 16'd5);

    // async reset mid-cycle after 3 samples
    step(1, 16'd30, 0, 0);
    chk("pre-reset fill_count", fc0, 3);
    valid_in = 0;
    #3 rst = 1;
    #1;
    chk_main("async rst", 0, 0, 0, 4'b1111, '0);
    @(negedge clk) rst = 0;

    // flush with a sample in FILL never sets overflow
    step(1, 16'd1, 0, 0);
    step(1, 16'd2, 1, 0);
    chk_main("flush no ovf", 0, 0, 0, 4'b0000, '0);

    // fresh fill after reset
    step(1, 16'd5, 0, 0);
    step(1, -16'sd3, 0, 0);
    step(1, 16'd7, 0, 0);
    chk("refill mid valid", lv0, 0);
    step(1, 16'd0, 0, 0);
    chk_main("refill", 1, 4, 0, 4'b1111, {16'd0, 16'd7, 16'd0, 16'd5});
    step(0, 16'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
